// File: rtl/uart_rx_deframer_if.sv
// ---------------------------------------------------------------------------
// uart_rx_deframer_if
//   Ready/valid byte channel between the UART receiver and its consumer.
//   master : receiver side   (drives data_out/data_out_valid, reads ready)
//   slave  : consumer side   (reads data_out/data_out_valid, drives ready)
//   data_out        8  received byte, stable while data_out_valid=1
//   data_out_valid  1  byte available in the holding register
//   data_out_ready  1  consumer takes the byte when valid&ready at posedge
// ---------------------------------------------------------------------------
interface uart_rx_deframer_if;
   logic [7:0] data_out;
   logic       data_out_valid;
   logic       data_out_ready;

   modport master (output data_out, output data_out_valid, input data_out_ready);
   modport slave  (input data_out, input data_out_valid, output data_out_ready);
endinterface

// File: rtl/uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// uart_rx_deframer
//   8N1 UART receiver, LSB first. Mid-bit sampling of a synchronized serial
//   line; each byte lands in a one-entry ready/valid holding register.
//   Optional macro UART_RX_FRAME_ERR_EN: a low stop bit drops the byte,
//   pulses frame_error for one cycle and requires the line to return high
//   before a new start bit is accepted. Without it frame_error is tied 0.
// Ports
//   clk         system clock, posedge
//   rst         synchronous active-high reset
//   serial_in   asynchronous UART line, idle high
//   rx          byte channel (master modport of uart_rx_deframer_if)
//   frame_error 1-cycle pulse on a bad stop bit (macro builds only)
// ---------------------------------------------------------------------------
module uart_rx_deframer #(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD_RATE  = 115_200
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       serial_in,
   uart_rx_deframer_if.master         rx,
   output logic                       frame_error
);
   localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
   localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
   localparam int CW               = $clog2(SYMBOL_EDGE_TIME + 1);
   localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLE_TIME - 1);
   localparam logic [CW-1:0] SYMBOL_LAST = CW'(SYMBOL_EDGE_TIME - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state;
   logic [CW-1:0] clock_counter;
   logic [2:0]    bit_counter;
   logic [7:0]    shift;
   logic          rx_m, rx_s;
   logic          stop_tick, byte_done, accept;

   // two-flop synchronizer, resets to the idle line level
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= serial_in;
         rx_s <= rx_m;
      end
   end

   // stop-bit sample instant; the byte is complete on this edge
   assign stop_tick = (state == STOP) && (clock_counter == SYMBOL_LAST);
   assign accept    = rx.data_out_valid & rx.data_out_ready;

`ifdef UART_RX_FRAME_ERR_EN
   logic armed;   // cleared by a bad stop, set again once the line is seen high
   assign byte_done = stop_tick & rx_s;
`else
   assign byte_done   = stop_tick;
   assign frame_error = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         clock_counter <= '0;
         bit_counter   <= '0;
         shift         <= '0;
`ifdef UART_RX_FRAME_ERR_EN
         armed         <= 1'b1;
         frame_error   <= 1'b0;
`endif
      end else begin
`ifdef UART_RX_FRAME_ERR_EN
         frame_error <= 1'b0;
`endif
         case (state)
            IDLE: begin
               clock_counter <= '0;
               bit_counter   <= '0;
`ifdef UART_RX_FRAME_ERR_EN
               if (rx_s) armed <= 1'b1;
               if (!rx_s && armed) state <= START;
`else
               if (!rx_s) state <= START;
`endif
            end
            START: begin
               if (clock_counter == SAMPLE_LAST) begin
                  clock_counter <= '0;
                  // a start bit that is high again at mid-bit was a glitch
                  state         <= rx_s ? IDLE : DATA;
               end else begin
                  clock_counter <= clock_counter + 1'b1;
               end
            end
            DATA: begin
               if (clock_counter == SYMBOL_LAST) begin
                  clock_counter <= '0;
                  shift         <= {rx_s, shift[7:1]};
                  bit_counter   <= bit_counter + 1'b1;
                  if (bit_counter == 3'd7) state <= STOP;
               end else begin
                  clock_counter <= clock_counter + 1'b1;
               end
            end
            STOP: begin
               if (stop_tick) begin
                  clock_counter <= '0;
                  state         <= IDLE;
`ifdef UART_RX_FRAME_ERR_EN
                  if (!rx_s) begin
                     frame_error <= 1'b1;
                     armed       <= 1'b0;
                  end
`endif
               end else begin
                  clock_counter <= clock_counter + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // holding register: a completed byte loads only if the slot is free or
   // being drained this cycle; otherwise it is an overrun and is dropped
   always_ff @(posedge clk) begin
      if (rst) begin
         rx.data_out       <= '0;
         rx.data_out_valid <= 1'b0;
      end else if (byte_done && (!rx.data_out_valid || accept)) begin
         rx.data_out       <= shift;
         rx.data_out_valid <= 1'b1;
      end else if (accept) begin
         rx.data_out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_uart_rx_deframer.sv
module tb_uart_rx_deframer;
   localparam int BIT_CYC = 50;
   localparam int LAT     = 2 + 25 + 9 * BIT_CYC + 1;  // serial_in fall -> valid

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic serial_in = 1'b1;
   logic frame_error;
   uart_rx_deframer_if rxif();

   uart_rx_deframer #(.CLOCK_FREQ(50_000_000), .BAUD_RATE(1_000_000)) dut (
      .clk(clk), .rst(rst), .serial_in(serial_in), .rx(rxif.master), .frame_error(frame_error)
   );

   always #5 clk = ~clk;

   int nvec = 0;
   int nerr = 0;
   int fe_cnt = 0;
   logic [7:0] got_q[$];

   // consumer-side monitor: a handshake seen here completes on the next posedge
   always @(negedge clk) begin
      if (!rst && rxif.data_out_valid && rxif.data_out_ready) got_q.push_back(rxif.data_out);
      if (frame_error) fe_cnt++;
   end

   task automatic idle(input int n);
      serial_in = 1'b1;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_ready();
      rxif.data_out_ready = 1'b1;
      @(posedge clk); #1;
      rxif.data_out_ready = 1'b0;
   endtask

   // drives one 10-bit frame, optionally a 1-cycle reset at cycle rst_at
   task automatic send_frame(input logic [7:0] b, input logic stp, input int rst_at,
                             output int first_vld, output logic [7:0] rd,
                             output logic rv, output logic rfe);
      logic [9:0] frm;
      frm = {stp, b, 1'b0};
      first_vld = -1; rd = 8'hFF; rv = 1'b1; rfe = 1'b1;
      for (int i = 0; i < 10 * BIT_CYC; i++) begin
         serial_in = frm[i / BIT_CYC];
         rst = (i == rst_at);
         @(posedge clk); #1;
         if (i == rst_at) begin
            rd = rxif.data_out; rv = rxif.data_out_valid; rfe = frame_error;
         end
         if (first_vld < 0 && rxif.data_out_valid) first_vld = i + 1;
      end
      rst = 1'b0;
      serial_in = 1'b1;
   endtask

   task automatic send(input logic [7:0] b);
      int fv; logic [7:0] rd; logic rv, rfe;
      send_frame(b, 1'b1, -1, fv, rd, rv, rfe);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      nvec++;
      if (rxif.data_out_valid !== 1'b0 || rxif.data_out !== 8'h00 || frame_error !== 1'b0) begin
         nerr++;
         $display("FAIL reset: valid=%b data=%h fe=%b, want 0/00/0",
                  rxif.data_out_valid, rxif.data_out, frame_error);
      end
      rst = 1'b0;
      idle(5);
   endtask

   task automatic test_single();
      int fv; logic [7:0] rd; logic rv, rfe;
      rxif.data_out_ready = 1'b0; got_q.delete();
      send_frame(8'h61, 1'b1, -1, fv, rd, rv, rfe);
      nvec++;
      if (fv !== LAT) begin nerr++; $display("FAIL latency: got %0d want %0d", fv, LAT); end
      idle(20);
      nvec++;
      if (rxif.data_out_valid !== 1'b1 || rxif.data_out !== 8'h61) begin
         nerr++; $display("FAIL hold: valid=%b data=%h want 1/61", rxif.data_out_valid, rxif.data_out);
      end
      pulse_ready();
      nvec++;
      if (rxif.data_out_valid !== 1'b0) begin nerr++; $display("FAIL accept_clear: valid=%b want 0", rxif.data_out_valid); end
      nvec++;
      if (got_q.size() != 1 || got_q[0] !== 8'h61) begin
         nerr++; $display("FAIL accept_data: n=%0d want 1 byte 61", got_q.size());
      end
   endtask

   task automatic test_glitch();
      rxif.data_out_ready = 1'b1; got_q.delete();
      serial_in = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      idle(60);
      nvec++;
      if (rxif.data_out_valid !== 1'b0 || got_q.size() != 0) begin
         nerr++; $display("FAIL glitch: valid=%b bytes=%0d want 0/0", rxif.data_out_valid, got_q.size());
      end
      send(8'h5A); idle(5);
      nvec++;
      if (got_q.size() != 1 || got_q[0] !== 8'h5A) begin
         nerr++; $display("FAIL after_glitch: n=%0d first=%h want 1 byte 5a", got_q.size(), got_q.size() ? got_q[0] : 8'h00);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp;
      rxif.data_out_ready = 1'b1; got_q.delete();
      for (int k = 0; k < 10; k++) send(8'h61 + 8'(k));
      idle(5);
      nvec++;
      if (got_q.size() != 10) begin nerr++; $display("FAIL b2b_count: got %0d want 10", got_q.size()); end
      for (int k = 0; k < 10 && k < got_q.size(); k++) begin
         exp = 8'h61 + 8'(k);
         nvec++;
         if (got_q[k] !== exp) begin nerr++; $display("FAIL b2b_byte%0d: got %h want %h", k, got_q[k], exp); end
      end
   endtask

   task automatic test_overrun();
      rxif.data_out_ready = 1'b0; got_q.delete();
      send(8'h55); send(8'hAA); idle(5);
      nvec++;
      if (rxif.data_out_valid !== 1'b1 || rxif.data_out !== 8'h55) begin
         nerr++; $display("FAIL overrun_hold: valid=%b data=%h want 1/55", rxif.data_out_valid, rxif.data_out);
      end
      pulse_ready();
      nvec++;
      if (rxif.data_out_valid !== 1'b0 || got_q.size() != 1 || got_q[0] !== 8'h55) begin
         nerr++; $display("FAIL overrun_accept: valid=%b n=%0d want 0 and one byte 55", rxif.data_out_valid, got_q.size());
      end
   endtask

   task automatic test_frame_error();
      int fv; logic [7:0] rd; logic rv, rfe;
      rxif.data_out_ready = 1'b1; got_q.delete(); fe_cnt = 0;
      send_frame(8'h3C, 1'b0, -1, fv, rd, rv, rfe);
      idle(60);
`ifdef UART_RX_FRAME_ERR_EN
      nvec++;
      if (got_q.size() != 0) begin nerr++; $display("FAIL ferr_drop: got %0d bytes want 0", got_q.size()); end
      nvec++;
      if (fe_cnt != 1) begin nerr++; $display("FAIL ferr_pulse: %0d cycles want 1", fe_cnt); end
`else
      nvec++;
      if (got_q.size() != 1 || got_q[0] !== 8'h3C) begin
         nerr++; $display("FAIL ferr_deliver: n=%0d want one byte 3c", got_q.size());
      end
      nvec++;
      if (fe_cnt != 0) begin nerr++; $display("FAIL ferr_tied: %0d cycles want 0", fe_cnt); end
`endif
      got_q.delete();
      send(8'h96); idle(5);
      nvec++;
      if (got_q.size() != 1 || got_q[0] !== 8'h96) begin
         nerr++; $display("FAIL ferr_recover: n=%0d want one byte 96", got_q.size());
      end
   endtask

   task automatic test_mid_reset();
      int fv; logic [7:0] rd; logic rv, rfe;
      rxif.data_out_ready = 1'b0; got_q.delete();
      send(8'h33); idle(5);
      nvec++;
      if (rxif.data_out_valid !== 1'b1) begin nerr++; $display("FAIL prereset_valid: got %b want 1", rxif.data_out_valid); end
      // cycle 270 falls inside data bit 4 (frame cycles 250..299)
      send_frame(8'hF0, 1'b1, 270, fv, rd, rv, rfe);
      nvec++;
      if (rd !== 8'h00 || rv !== 1'b0 || rfe !== 1'b0) begin
         nerr++; $display("FAIL midreset: data=%h valid=%b fe=%b want 00/0/0", rd, rv, rfe);
      end
      idle(5);
      nvec++;
      if (rxif.data_out_valid !== 1'b0) begin nerr++; $display("FAIL partial_discard: valid=%b want 0", rxif.data_out_valid); end
      rxif.data_out_ready = 1'b1;
      send(8'h81); idle(5);
      nvec++;
      if (got_q.size() != 1 || got_q[0] !== 8'h81) begin
         nerr++; $display("FAIL after_reset: n=%0d want one byte 81", got_q.size());
      end
   endtask

   initial begin
      rxif.data_out_ready = 1'b0;
      #1;
      test_reset();
      test_single();
      test_glitch();
      test_back_to_back();
      test_overrun();
      test_frame_error();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
